divisor_seq: RTL and testbench

DIVISOR_SEQ -- requirements
Module: divisor_seq

---
 rtl/divisor_seq.sv | 189 ++++++++++++++++++
 tb/tb_divisor_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
// -----------------------------------------------------------------------------
// divisor_seq
// Sequential restoring divider: a 2N-bit unsigned dividend divided by an N-bit
// unsigned divisor. It produces one quotient bit per clock cycle, N cycles in
// total, after a one-cycle check for a zero divisor or a quotient that will
// not fit in N bits.
//
// Ports
//   Clk        system clock, rising edge
//   Rst        asynchronous reset, active low
//   St         start request; level-sensitive and sampled only while idle
//   Dividendo  [2N-1:0] unsigned dividend, captured on the start edge
//   Divisor    [N-1:0]  unsigned divisor, captured on the start edge
//   Quociente  [N-1:0]  registered quotient (0 on error)
//   Resto      [N-1:0]  registered remainder (0 on error)
//   Idle       high while the FSM is idle
//   Done       one-cycle pulse when a result or an error is presented
//   DivZero    registered flag: last operation had a zero divisor
//   Overflow   registered flag: last quotient did not fit in N bits
//
// Result registers and flags change only on the edge entering FINISH. They
// hold between operations.
// -----------------------------------------------------------------------------
module divisor_seq #(
  parameter int N = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           St,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           Idle,
  output logic           Done,
  output logic           DivZero,
  output logic           Overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    FINISH
  } state_t;

  state_t        state_q;
  state_t        state_d;

  // rem_q starts as the upper dividend half and becomes the partial remainder.
  // lo_q starts as the lower dividend half. Each step shifts it left: the
  // dividend MSB leaves at the top and the new quotient bit enters at the
  // bottom. After N steps, lo_q holds the whole quotient.
  logic [N-1:0]  rem_q;
  logic [N-1:0]  lo_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;

  logic          step_qbit;
  logic [N-1:0]  step_rem;

  // One restoring step. The trial is N+1 bits wide, so the compare keeps the
  // bit shifted out of the remainder. When the subtraction is taken, the true
  // difference is below the divisor. That means its low N bits are exact, and
  // N-bit modular subtraction gives the correct remainder.
  function automatic logic [N:0] restore_step(input logic [N-1:0] rem,
                                              input logic         nxt,
                                              input logic [N-1:0] dvs);
    logic [N:0] trial;
    trial = {rem, nxt};
    if (trial >= {1'b0, dvs}) begin
      restore_step = {1'b1, trial[N-1:0] - dvs};
    end else begin
      restore_step = {1'b0, trial[N-1:0]};
    end
  endfunction

  always_comb begin
    {step_qbit, step_rem} = restore_step(rem_q, lo_q[N-1], dvs_q);
  end

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    Idle    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        Idle = 1'b1;
        if (St) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A zero divisor also satisfies rem >= dvs, so both errors go straight
        // to FINISH.
        if (rem_q >= dvs_q) begin
          state_d = FINISH;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (cnt_q == '0) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, iteration and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rem_q     <= '0;
      lo_q      <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      Quociente <= '0;
      Resto     <= '0;
      DivZero   <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (St) begin
            rem_q <= Dividendo[2*N-1:N];
            lo_q  <= Dividendo[N-1:0];
            dvs_q <= Divisor;
          end
        end
        CHECK: begin
          if (dvs_q == '0) begin
            DivZero   <= 1'b1;
            Overflow  <= 1'b0;
            Quociente <= '0;
            Resto     <= '0;
          end else if (rem_q >= dvs_q) begin
            DivZero   <= 1'b0;
            Overflow  <= 1'b1;
            Quociente <= '0;
            Resto     <= '0;
          end else begin
            cnt_q <= CW'(N - 1);
          end
        end
        ITER: begin
          rem_q <= step_rem;
          lo_q  <= {lo_q[N-2:0], step_qbit};
          if (cnt_q == '0) begin
            // Last step: publish the result together with the entry to FINISH.
            Quociente <= {lo_q[N-2:0], step_qbit};
            Resto     <= step_rem;
            DivZero   <= 1'b0;
            Overflow  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_seq.sv
module tb_divisor_seq;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        St;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Idle;
  logic        Done;
  logic        DivZero;
  logic        Overflow;

  int n_vec = 0;
  int n_err = 0;

  divisor_seq #(.N(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .Idle      (Idle),
    .Done      (Done),
    .DivZero   (DivZero),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one operation, scramble the operand inputs after the start edge,
  // count the edges until Done, and check the result and the return to idle.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input int lat,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eov, input string tag);
    int n;
    Dividendo = a;
    Divisor   = b;
    St        = 1'b1;
    tick();
    St        = 1'b0;
    Dividendo = $urandom;
    Divisor   = 16'($urandom_range(0, 65535));
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " quociente"}, Quociente, eq);
    chk({tag, " resto"}, Resto, er);
    chk({tag, " divzero"}, DivZero, edz);
    chk({tag, " overflow"}, Overflow, eov);
    tick();
    chk({tag, " done pulse"}, Done, 1'b0);
    chk({tag, " idle after"}, Idle, 1'b1);
  endtask

  initial begin
    Rst       = 1'b0;
    St        = 1'b0;
    Dividendo = '0;
    Divisor   = '0;
    #3;
    chk("reset idle", Idle, 1'b1);
    chk("reset done", Done, 1'b0);
    chk("reset quociente", Quociente, 16'd0);
    chk("reset resto", Resto, 16'd0);
    chk("reset divzero", DivZero, 1'b0);
    chk("reset overflow", Overflow, 1'b0);
    tick();
    tick();
    Rst = 1'b1;
    tick();
    chk("idle holds without St", Idle, 1'b1);

    // 143/13 with St held high, followed by a back-to-back 8006001/4001.
    Dividendo = 32'd143;
    Divisor   = 16'd13;
    St        = 1'b1;
    tick();
    chk("b2b first left idle", Idle, 1'b0);
    Dividendo = 32'd8006001;
    Divisor   = 16'd4001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("b2b first no early done", Done, 1'b0);
    end
    tick();
    chk("b2b first done", Done, 1'b1);
    chk("b2b first quociente", Quociente, 16'd11);
    chk("b2b first resto", Resto, 16'd0);
    chk("b2b first divzero", DivZero, 1'b0);
    chk("b2b first overflow", Overflow, 1'b0);
    tick();
    chk("b2b idle gap", Idle, 1'b1);
    chk("b2b gap done low", Done, 1'b0);
    chk("b2b quociente holds", Quociente, 16'd11);
    tick();
    chk("b2b second started", Idle, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("b2b second no early done", Done, 1'b0);
    end
    tick();
    chk("b2b second done", Done, 1'b1);
    chk("b2b second quociente", Quociente, 16'd2001);
    chk("b2b second resto", Resto, 16'd0);
    St = 1'b0;
    tick();
    chk("b2b end idle", Idle, 1'b1);
    tick();
    chk("b2b stays idle", Idle, 1'b1);

    do_op(32'hFFFE0001, 16'd65535, 17, 16'd65535, 16'd0, 1'b0, 1'b0, "max");
    do_op(32'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0, 1'b0, "100/7");
    do_op(32'd50, 16'd0, 1, 16'd0, 16'd0, 1'b1, 1'b0, "divzero");
    do_op(32'h00100000, 16'd16, 1, 16'd0, 16'd0, 1'b0, 1'b1, "overflow");
    chk("overflow holds", Overflow, 1'b1);

    // Abort 1000/3 with reset during the fifth ITER cycle.
    Dividendo = 32'd1000;
    Divisor   = 16'd3;
    St        = 1'b1;
    tick();
    St = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("abort no done", Done, 1'b0);
    end
    #2;
    Rst = 1'b0;
    #1;
    chk("abort idle", Idle, 1'b1);
    chk("abort done", Done, 1'b0);
    chk("abort quociente", Quociente, 16'd0);
    chk("abort resto", Resto, 16'd0);
    chk("abort divzero", DivZero, 1'b0);
    chk("abort overflow", Overflow, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort in reset done", Done, 1'b0);
    end
    Rst = 1'b1;
    tick();
    chk("abort resume idle", Idle, 1'b1);
    chk("abort resume done", Done, 1'b0);
    do_op(32'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0, 1'b0, "1000/3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
